mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_pkg.sv | 23 ++
 rtl/mux16_rr_arbiter_if.sv | 35 +++
 rtl/mux16_rr_arbiter_pick.sv | 24 ++
 rtl/mux16_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mux16_pkg.sv
// Shared constants, FSM state encoding and the word-extraction helper for the
// 16-way round-robin word arbiter.
package mux16_pkg;

    localparam int DATA_W   = 32;
    localparam int N_REQ    = 16;
    localparam int CARD_W   = 5;
    localparam int LOCK_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Requester 0 sits at the top of the packed bus, requester 15 at the bottom.
    function automatic logic [DATA_W-1:0] get_word(
        input logic [N_REQ*DATA_W-1:0] data,
        input logic [3:0]              idx
    );
        get_word = data[(N_REQ - 1 - int'(idx)) * DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester-side and consumer-side bus of the 16-way word arbiter.
// The req_lock lane exists only when MUX16_ARB_LOCK_EN is defined.
interface mux16_rr_arbiter_if;
    import mux16_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [CARD_W-1:0]       out_card;
    logic                    busy;
`ifdef MUX16_ARB_LOCK_EN
    logic [N_REQ-1:0]        req_lock;

    modport master (
        input  req_valid, req_data, req_lock, out_ready,
        output req_ack, out_valid, out_data, out_card, busy
    );
    modport slave (
        output req_valid, req_data, req_lock, out_ready,
        input  req_ack, out_valid, out_data, out_card, busy
    );
`else
    modport master (
        input  req_valid, req_data, out_ready,
        output req_ack, out_valid, out_data, out_card, busy
    );
    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ack, out_valid, out_data, out_card, busy
    );
`endif
endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// rr_pick16: combinational rotating-priority search starting at ptr.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  logic [3:0]       ptr,
    output logic [3:0]       grant_idx,
    output logic             any
);

    logic [3:0] idx_s;

    // Scan from the farthest slot back to ptr so the nearest valid slot wins last.
    always_comb begin
        grant_idx = 4'd0;
        idx_s     = 4'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s     = ptr + 4'(k);
            grant_idx = req_valid[idx_s] ? idx_s : grant_idx;
        end
        any = (req_valid != 16'h0000);
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 16-way 32-bit word selector.
// Optional sticky-lock regrant is enabled by defining MUX16_ARB_LOCK_EN.
module mux16_rr_arbiter
    import mux16_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    mux16_rr_arbiter_if.master bus
);

    arb_state_e          state_r;
    logic [3:0]          ptr_r;
    logic [N_REQ-1:0]    req_ack_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [CARD_W-1:0]   out_card_r;
    logic                busy_r;

    logic [3:0]          grant_s;
    logic                any_s;
    logic [3:0]          sel_idx_s;
    logic                locked_s;

    rr_pick16 u_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr_r),
        .grant_idx (grant_s),
        .any       (any_s)
    );

`ifdef MUX16_ARB_LOCK_EN
    logic [2:0] lock_cnt_r;

    // A nonzero count means the held requester was locked when last granted.
    always_comb begin
        locked_s  = (lock_cnt_r != 3'd0) && (lock_cnt_r < 3'(LOCK_MAX))
                    && bus.req_valid[out_card_r[3:0]];
        sel_idx_s = locked_s ? out_card_r[3:0] : grant_s;
    end
`else
    // Pure round-robin: the picker's choice is always taken.
    always_comb begin
        locked_s  = 1'b0;
        sel_idx_s = grant_s;
    end
`endif

    // Two-state FSM with all outputs registered; HOLD never grants on its exit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= 4'd0;
            req_ack_r   <= 16'h0000;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_card_r  <= 5'd0;
            busy_r      <= 1'b0;
`ifdef MUX16_ARB_LOCK_EN
            lock_cnt_r  <= 3'd0;
`endif
        end else begin
            req_ack_r <= 16'h0000;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        out_data_r           <= get_word(bus.req_data, sel_idx_s);
                        out_card_r           <= {1'b0, sel_idx_s};
                        out_valid_r          <= 1'b1;
                        busy_r               <= 1'b1;
                        req_ack_r[sel_idx_s] <= 1'b1;
                        state_r              <= HOLD;
                        if (!locked_s) begin
                            ptr_r <= grant_s + 4'd1;
                        end
`ifdef MUX16_ARB_LOCK_EN
                        if (locked_s) begin
                            lock_cnt_r <= lock_cnt_r + 3'd1;
                        end else begin
                            lock_cnt_r <= bus.req_lock[grant_s] ? 3'd1 : 3'd0;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ack   = req_ack_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_card  = out_card_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized + directed bench for mux16_rr_arbiter against a queue-free
// behavioural model of the round-robin rules (lock rules when MUX16_ARB_LOCK_EN).
module tb_mux16_rr_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux16_rr_arbiter_if bus_if ();

    mux16_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_ptr;
    bit          m_hold;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_card;
    logic [15:0] m_ack;
    int          m_lockcnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  g;
        bit  lk;
        if (!rst_n) begin
            m_ptr = 0; m_hold = 0; m_valid = 0; m_data = 0; m_card = 0; m_ack = 0; m_lockcnt = 0;
        end else begin
            m_ack = 0;
            if (m_hold) begin
                if (bus_if.out_ready) begin
                    m_hold  = 0;
                    m_valid = 0;
                end
            end else if (bus_if.req_valid != 0) begin
                g  = -1;
                lk = 0;
`ifdef MUX16_ARB_LOCK_EN
                if (m_lockcnt > 0 && m_lockcnt < 4 && bus_if.req_valid[m_card]) begin
                    g = m_card;
                    lk = 1;
                    m_lockcnt++;
                end
`endif
                if (!lk) begin
                    for (int k = 0; k < 16; k++)
                        if (g < 0 && bus_if.req_valid[(m_ptr + k) % 16]) g = (m_ptr + k) % 16;
                    m_ptr = (g + 1) % 16;
`ifdef MUX16_ARB_LOCK_EN
                    m_lockcnt = bus_if.req_lock[g] ? 1 : 0;
`endif
                end
                m_data  = bus_if.req_data[511 - 32*g -: 32];
                m_card  = g;
                m_valid = 1;
                m_ack   = 16'h0001 << g;
                m_hold  = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        check_eq("out_card",  32'(bus_if.out_card),  32'(m_card));
        check_eq("out_data",  bus_if.out_data,       m_data);
        check_eq("req_ack",   32'(bus_if.req_ack),   32'(m_ack));
        check_eq("busy",      32'(bus_if.busy),      32'(m_hold));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic [15:0] v, input logic rdy, input int n);
        bus_if.req_valid = v;
        bus_if.out_ready = rdy;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_words();
        for (int i = 0; i < 16; i++)
            bus_if.req_data[511 - 32*i -: 32] = 32'hA000_0000 | 32'(i);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus_if.req_valid = 16'hFFFF;
        bus_if.out_ready = 1'b1;
        bus_if.req_data  = '0;
`ifdef MUX16_ARB_LOCK_EN
        bus_if.req_lock  = 16'h0000;
`endif
        fill_words();

        // Reset with every requester pending
        drive(16'hFFFF, 1'b1, 2);
        check_eq("reset_card", 32'(bus_if.out_card), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("first_grant_top_word", bus_if.out_data, 32'hA000_0000);

        // All-valid round robin
        drive(16'hFFFF, 1'b1, 40);

        // Drain, then single requester 5
        drive(16'h0000, 1'b1, 2);
        bus_if.req_data[511 - 32*5 -: 32] = 32'hDEAD_BEEF;
        drive(16'h0020, 1'b1, 1);
        check_eq("single_card5", 32'(bus_if.out_card), 32'd5);
        check_eq("single_ack5", 32'(bus_if.req_ack), 32'h0000_0020);
        drive(16'h0000, 1'b1, 1);
        drive(16'h0040, 1'b1, 1);
        check_eq("ptr6_grant", 32'(bus_if.out_card), 32'd6);
        drive(16'h0000, 1'b1, 1);

        // Wrap-around: bring ptr to 15, then bits 2 and 15
        drive(16'h4000, 1'b1, 1);
        drive(16'h0000, 1'b1, 1);
        drive(16'h8004, 1'b1, 1);
        check_eq("wrap_first15", 32'(bus_if.out_card), 32'd15);
        drive(16'h0004, 1'b1, 2);
        check_eq("wrap_then2", 32'(bus_if.out_card), 32'd2);
        drive(16'h0000, 1'b1, 1);
        drive(16'h4000, 1'b1, 1);
        drive(16'h0000, 1'b1, 1);
        drive(16'h0004, 1'b1, 1);
        check_eq("wrap_only2", 32'(bus_if.out_card), 32'd2);

        // Backpressure: ten stalled cycles, then release
        drive(16'hFFFF, 1'b0, 10);
        drive(16'hFFFF, 1'b1, 4);

        // Reset in the middle of a HOLD
        drive(16'hFFFF, 1'b0, 2);
        rst_n = 1'b0;
        tick();
        check_eq("mid_hold_reset_valid", 32'(bus_if.out_valid), 32'd0);
        rst_n = 1'b1;
        drive(16'hFFFF, 1'b1, 1);
        check_eq("after_reset_ptr0", 32'(bus_if.out_card), 32'd0);
        drive(16'h0000, 1'b1, 1);

`ifdef MUX16_ARB_LOCK_EN
        // Sticky lock on 3 with 1 and 3 pending
        bus_if.req_lock = 16'h0008;
        drive(16'h000A, 1'b1, 14);
        bus_if.req_lock = 16'h0000;
        drive(16'h0000, 1'b1, 2);
`endif

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            case ($urandom_range(0, 3))
                0: bus_if.req_valid = 16'h0000;
                1: bus_if.req_valid = 16'h0001 << $urandom_range(0, 15);
                2: bus_if.req_valid = 16'($urandom);
                default: bus_if.req_valid = 16'hFFFF;
            endcase
            for (int i = 0; i < 16; i++) bus_if.req_data[32*i +: 32] = $urandom;
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX16_ARB_LOCK_EN
            bus_if.req_lock = 16'($urandom) & 16'($urandom);
`endif
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
